// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control FSM: states, opcodes, instruction classes.
package cpu_ctrl_pkg;

   localparam logic [2:0] S_WAIT   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_WR_IMM = 3'd2;
   localparam logic [2:0] S_GET_A  = 3'd3;
   localparam logic [2:0] S_GET_B  = 3'd4;
   localparam logic [2:0] S_ALU    = 3'd5;
   localparam logic [2:0] S_WR_REG = 3'd6;

   typedef enum logic [2:0] {
      ST_WAIT   = S_WAIT,
      ST_DECODE = S_DECODE,
      ST_WR_IMM = S_WR_IMM,
      ST_GET_A  = S_GET_A,
      ST_GET_B  = S_GET_B,
      ST_ALU    = S_ALU,
      ST_WR_REG = S_WR_REG
   } state_e;

   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;

   localparam logic [1:0] OP_MOVI  = 2'b10;
   localparam logic [1:0] OP_MOVR  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_CMP   = 2'b01;
   localparam logic [1:0] OP_AND   = 2'b10;
   localparam logic [1:0] OP_MVN   = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b10;

   // Instruction class: what path the FSM takes after DECODE.
   typedef enum logic [2:0] {
      CLS_ILL  = 3'd0,   // unsupported encoding, back to WAIT
      CLS_MOVI = 3'd1,   // MOV Rn,#imm8
      CLS_MOVR = 3'd2,   // MOV Rd,Rm{,sh}
      CLS_AB   = 3'd3,   // ADD / AND: two operands, write-back
      CLS_CMP  = 3'd4,   // two operands, status only
      CLS_MVN  = 3'd5    // one operand, write-back
   } cls_e;

endpackage

// File: rtl/cpu_ctrl_instr_decoder.sv
// Combinational IR decode: register fields, sign-extended immediates, class.
module instr_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic [DW-1:0] ir_i,
   output logic [1:0]    op_o,
   output logic [RW-1:0] rn_o,
   output logic [RW-1:0] rd_o,
   output logic [1:0]    sh_o,
   output logic [RW-1:0] rm_o,
   output logic [DW-1:0] sximm8_o,
   output logic [DW-1:0] sximm5_o,
   output cls_e          cls_o
);

   logic [2:0] opcode;

   assign opcode   = ir_i[15:13];
   assign op_o     = ir_i[12:11];
   assign rn_o     = ir_i[10:8];
   assign rd_o     = ir_i[7:5];
   assign sh_o     = ir_i[4:3];
   assign rm_o     = ir_i[2:0];
   assign sximm8_o = {{(DW-8){ir_i[7]}}, ir_i[7:0]};
   assign sximm5_o = {{(DW-5){ir_i[4]}}, ir_i[4:0]};

   // Map opcode/op to the instruction class the FSM branches on.
   always_comb begin
      cls_o = CLS_ILL;
      if (opcode == OPC_MOV) begin
         if (op_o == OP_MOVI)      cls_o = CLS_MOVI;
         else if (op_o == OP_MOVR) cls_o = CLS_MOVR;
      end else if (opcode == OPC_ALU) begin
         case (op_o)
            OP_ADD:  cls_o = CLS_AB;
            OP_CMP:  cls_o = CLS_CMP;
            OP_AND:  cls_o = CLS_AB;
            default: cls_o = CLS_MVN;
         endcase
      end
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Control FSM plus instruction register; drives register file and latch controls.
module cpu_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s,
   input  logic          load,
   input  logic [DW-1:0] in,
   output logic          w,
   output logic [RW-1:0] readnum,
   output logic [RW-1:0] writenum,
   output logic          write,
   output logic          loada,
   output logic          loadb,
   output logic          loadc,
   output logic          loads,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    vsel,
   output logic [1:0]    shift,
   output logic [1:0]    aluop,
   output logic [DW-1:0] sximm8,
   output logic [DW-1:0] sximm5
);

   state_e        state_q, state_d;
   logic [DW-1:0] ir_q, ir_d;

   logic [1:0]    op;
   logic [RW-1:0] rn, rd, rm;
   logic [1:0]    sh;
   cls_e          cls;

   instr_decoder #(.DW(DW), .RW(RW)) u_dec (
      .ir_i     (ir_q),
      .op_o     (op),
      .rn_o     (rn),
      .rd_o     (rd),
      .sh_o     (sh),
      .rm_o     (rm),
      .sximm8_o (sximm8),
      .sximm5_o (sximm5),
      .cls_o    (cls)
   );

   // IR only accepts a new word while idle; the same-cycle load+s case
   // works because DECODE sees the freshly loaded IR.
   always_comb begin
      ir_d = ir_q;
      if (load && state_q == ST_WAIT) ir_d = in;
   end

   // State and IR registers; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state sequencing per instruction class.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT:   if (s) state_d = ST_DECODE;
         ST_DECODE: begin
            case (cls)
               CLS_MOVI:         state_d = ST_WR_IMM;
               CLS_AB, CLS_CMP:  state_d = ST_GET_A;
               CLS_MOVR, CLS_MVN: state_d = ST_GET_B;
               default:          state_d = ST_WAIT;
            endcase
         end
         ST_GET_A:  state_d = ST_GET_B;
         ST_GET_B:  state_d = ST_ALU;
         ST_ALU:    state_d = (cls == CLS_CMP) ? ST_WAIT : ST_WR_REG;
         ST_WR_IMM: state_d = ST_WAIT;
         ST_WR_REG: state_d = ST_WAIT;
         default:   state_d = ST_WAIT;
      endcase
   end

   // Moore outputs from state and IR fields; everything idle by default.
   always_comb begin
      w        = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = VSEL_C;
      shift    = 2'b00;
      aluop    = 2'b00;
      case (state_q)
         ST_WAIT:  w = 1'b1;
         ST_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
         end
         ST_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         ST_ALU: begin
            shift = sh;
            aluop = (cls == CLS_MOVR) ? 2'b00 : op;
            asel  = (cls == CLS_MOVR);
            loads = (cls == CLS_CMP);
            loadc = (cls != CLS_CMP);
         end
         ST_WR_REG: begin
            writenum = rd;
            vsel     = VSEL_C;
            write    = 1'b1;
         end
         ST_WR_IMM: begin
            writenum = rn;
            vsel     = VSEL_IMM;
            write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed vector table plus latency/write-count sequences for cpu_ctrl_fsm.
module tb_cpu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s, load;
   logic [15:0] in;
   logic        w, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, aluop;
   logic [15:0] sximm8, sximm5;

   int nchk  = 0;
   int nfail = 0;

   cpu_ctrl_fsm #(.DW(16), .RW(3)) dut (
      .clk(clk), .rst_n(rst_n), .s(s), .load(load), .in(in), .w(w),
      .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .aluop(aluop),
      .sximm8(sximm8), .sximm5(sximm5)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       w;
      logic [2:0] rn;
      logic [2:0] wn;
      logic       wr, la, lb, lc, ls, as, bs;
      logic [1:0] vs, sh, alu;
   } ctl_t;

   typedef struct {
      logic        rst, ld, st, edge_en;
      logic [15:0] din;
      ctl_t        c;
      logic [15:0] x8, x5;
   } vec_t;

   vec_t vecs[$];

   function automatic ctl_t c_idle();   ctl_t c = '0; return c; endfunction
   function automatic ctl_t c_wait();   ctl_t c = '0; c.w = 1'b1; return c; endfunction
   function automatic ctl_t c_geta(input logic [2:0] r);
      ctl_t c = '0; c.rn = r; c.la = 1'b1; return c;
   endfunction
   function automatic ctl_t c_getb(input logic [2:0] r);
      ctl_t c = '0; c.rn = r; c.lb = 1'b1; return c;
   endfunction
   function automatic ctl_t c_alu(input logic [1:0] sh, input logic [1:0] alu,
                                  input logic as, input logic cmp);
      ctl_t c = '0; c.sh = sh; c.alu = alu; c.as = as; c.ls = cmp; c.lc = ~cmp; return c;
   endfunction
   function automatic ctl_t c_wreg(input logic [2:0] r);
      ctl_t c = '0; c.wn = r; c.wr = 1'b1; c.vs = 2'b00; return c;
   endfunction
   function automatic ctl_t c_wimm(input logic [2:0] r);
      ctl_t c = '0; c.wn = r; c.wr = 1'b1; c.vs = 2'b10; return c;
   endfunction

   task automatic add(input logic rst, input logic ld, input logic st, input logic [15:0] din,
                      input logic e, input ctl_t c, input logic [15:0] x8, input logic [15:0] x5);
      vec_t v;
      v.rst = rst; v.ld = ld; v.st = st; v.din = din; v.edge_en = e;
      v.c = c; v.x8 = x8; v.x5 = x5;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic ctl_t sample();
      ctl_t c;
      c.w = w; c.rn = readnum; c.wn = writenum; c.wr = write; c.la = loada;
      c.lb = loadb; c.lc = loadc; c.ls = loads; c.as = asel; c.bs = bsel;
      c.vs = vsel; c.sh = shift; c.alu = aluop;
      return c;
   endfunction

   // Issue load+s with one instruction and measure cycles until w and writes seen.
   task automatic run_lat(input logic [15:0] instr, input int exp_lat, input int exp_wr);
      int n, nw;
      load = 1'b1; s = 1'b1; in = instr;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0; in = 16'h0;
      n = 1; nw = 0;
      while (!w && n < 20) begin
         nw += int'(write);
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("latency %h", instr), 64'(n), 64'(exp_lat));
      check($sformatf("writes %h", instr), 64'(nw), 64'(exp_wr));
   endtask

   initial begin
      rst_n = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0;

      // reset state
      add(0,0,0,16'h0,   0, c_wait(), 16'h0000, 16'h0000);
      // MOV R3,#-2
      add(1,1,1,16'hD3FE,1, c_idle(), 16'hFFFE, 16'hFFFE);
      add(1,0,0,16'h0,   1, c_wimm(3), 16'hFFFE, 16'hFFFE);
      add(1,0,0,16'h0,   1, c_wait(), 16'hFFFE, 16'hFFFE);
      // ADD R2,R1,R0,LSL#1: load alone, then s; load/s while busy ignored
      add(1,1,0,16'hA148,1, c_wait(), 16'h0048, 16'h0008);
      add(1,0,1,16'h0,   1, c_idle(), 16'h0048, 16'h0008);
      add(1,0,0,16'h0,   1, c_geta(1), 16'h0048, 16'h0008);
      add(1,1,1,16'hFFFF,1, c_getb(0), 16'h0048, 16'h0008);
      add(1,1,1,16'hFFFF,1, c_alu(2'b01,2'b00,0,0), 16'h0048, 16'h0008);
      add(1,0,0,16'h0,   1, c_wreg(2), 16'h0048, 16'h0008);
      add(1,0,0,16'h0,   1, c_wait(), 16'h0048, 16'h0008);
      add(1,0,0,16'h0,   1, c_wait(), 16'h0048, 16'h0008);
      // CMP R1,R0
      add(1,1,1,16'hA900,1, c_idle(), 16'h0000, 16'h0000);
      add(1,0,0,16'h0,   1, c_geta(1), 16'h0000, 16'h0000);
      add(1,0,0,16'h0,   1, c_getb(0), 16'h0000, 16'h0000);
      add(1,0,0,16'h0,   1, c_alu(2'b00,2'b01,0,1), 16'h0000, 16'h0000);
      add(1,0,0,16'h0,   1, c_wait(), 16'h0000, 16'h0000);
      // MOV R4,R5
      add(1,1,1,16'hC085,1, c_idle(), 16'hFF85, 16'h0005);
      add(1,0,0,16'h0,   1, c_getb(5), 16'hFF85, 16'h0005);
      add(1,0,0,16'h0,   1, c_alu(2'b00,2'b00,1,0), 16'hFF85, 16'h0005);
      add(1,0,0,16'h0,   1, c_wreg(4), 16'hFF85, 16'h0005);
      add(1,0,0,16'h0,   1, c_wait(), 16'hFF85, 16'h0005);
      // MVN R7,R3,LSR
      add(1,1,1,16'hB8F3,1, c_idle(), 16'hFFF3, 16'hFFF3);
      add(1,0,0,16'h0,   1, c_getb(3), 16'hFFF3, 16'hFFF3);
      add(1,0,0,16'h0,   1, c_alu(2'b10,2'b11,0,0), 16'hFFF3, 16'hFFF3);
      add(1,0,0,16'h0,   1, c_wreg(7), 16'hFFF3, 16'hFFF3);
      add(1,0,0,16'h0,   1, c_wait(), 16'hFFF3, 16'hFFF3);
      // AND R6,R2,R1
      add(1,1,1,16'hB2C1,1, c_idle(), 16'hFFC1, 16'h0001);
      add(1,0,0,16'h0,   1, c_geta(2), 16'hFFC1, 16'h0001);
      add(1,0,0,16'h0,   1, c_getb(1), 16'hFFC1, 16'h0001);
      add(1,0,0,16'h0,   1, c_alu(2'b00,2'b10,0,0), 16'hFFC1, 16'h0001);
      add(1,0,0,16'h0,   1, c_wreg(6), 16'hFFC1, 16'h0001);
      add(1,0,0,16'h0,   1, c_wait(), 16'hFFC1, 16'h0001);
      // illegal opcodes: 0000 and 110/01
      add(1,1,1,16'h0000,1, c_idle(), 16'h0000, 16'h0000);
      add(1,0,0,16'h0,   1, c_wait(), 16'h0000, 16'h0000);
      add(1,1,1,16'hC8FF,1, c_idle(), 16'hFFFF, 16'hFFFF);
      add(1,0,0,16'h0,   1, c_wait(), 16'hFFFF, 16'hFFFF);
      // reset during GET_B of ADD: immediate effect, no write afterwards
      add(1,1,1,16'hA148,1, c_idle(), 16'h0048, 16'h0008);
      add(1,0,0,16'h0,   1, c_geta(1), 16'h0048, 16'h0008);
      add(1,0,0,16'h0,   1, c_getb(0), 16'h0048, 16'h0008);
      add(0,0,0,16'h0,   0, c_wait(), 16'h0000, 16'h0000);
      add(0,0,0,16'h0,   1, c_wait(), 16'h0000, 16'h0000);
      add(1,0,0,16'h0,   1, c_wait(), 16'h0000, 16'h0000);
      add(1,0,0,16'h0,   1, c_wait(), 16'h0000, 16'h0000);

      foreach (vecs[i]) begin
         rst_n = vecs[i].rst; load = vecs[i].ld; s = vecs[i].st; in = vecs[i].din;
         if (vecs[i].edge_en) begin
            @(posedge clk); #1;
         end else begin
            #1;
         end
         check($sformatf("vec%0d ctl", i), 64'(sample()), 64'(vecs[i].c));
         check($sformatf("vec%0d imm", i), {32'h0, sximm8, sximm5},
               {32'h0, vecs[i].x8, vecs[i].x5});
      end

      // End-to-end latency and write-pulse count per instruction type.
      run_lat(16'hD3FE, 3, 1);
      run_lat(16'hA900, 5, 0);
      run_lat(16'hC085, 5, 1);
      run_lat(16'hB8F3, 5, 1);
      run_lat(16'hA148, 6, 1);
      run_lat(16'hB2C1, 6, 1);
      run_lat(16'h0000, 2, 0);
      run_lat(16'hC800, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
